// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward controller for the 5-stage MIPS pipeline.
// Freezes the pipe on multicycle data-memory waits, squashes on taken branches,
// inserts bubbles on data hazards and supplies EXE forwarding selects.
// A watchdog latches mem_err when a memory access waits MEM_TIMEOUT cycles.
// Build option: define FORWARDING_EN to enable operand forwarding. Then only
// load-use hazards stall. Without it the forwarding selects are tied to 00, and
// any RAW hazard against EXE or MEM stalls.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic [4:0]       exe_src1,
    input  logic [4:0]       exe_src2,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [4:0]       wb_dest,
    input  logic             wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             if_flush,
    output logic             id_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              freeze;
    logic              hazard;
    logic              hazard_stall;
    logic              stall_inc;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    // True when the ID instruction reads the given (non-zero) register.
    function automatic logic id_reads(input logic [4:0] dest,
                                      input logic       valid,
                                      input logic [4:0] src1,
                                      input logic [4:0] src2,
                                      input logic       two_src);
        return valid && (dest != 5'd0) &&
               ((src1 == dest) || (two_src && (src2 == dest)));
    endfunction

    // Forwarding select for one EXE operand: the younger MEM result wins over WB.
    function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                            input logic [4:0] m_dest,
                                            input logic       m_wb,
                                            input logic [4:0] w_dest,
                                            input logic       w_wb);
        if (m_wb && (m_dest != 5'd0) && (m_dest == src)) begin
            return 2'b01;
        end else if (w_wb && (w_dest != 5'd0) && (w_dest == src)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

`ifdef FORWARDING_EN
    // Hazard detection and forwarding selects when forwarding is available.
    always_comb begin
        hazard    = exe_mem_r_en && exe_wb_en &&
                    id_reads(exe_dest, id_valid, id_src1, id_src2, id_two_src);
        fwd_a_raw = fwd_pick(exe_src1, mem_dest, mem_wb_en, wb_dest, wb_en);
        fwd_b_raw = fwd_pick(exe_src2, mem_dest, mem_wb_en, wb_dest, wb_en);
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exe_src1, exe_src2, exe_mem_r_en, wb_dest, wb_en};

    // Hazard detection without forwarding: any pending writer in EXE or MEM stalls ID.
    always_comb begin
        hazard    = (exe_wb_en && id_reads(exe_dest, id_valid, id_src1, id_src2, id_two_src)) ||
                    (mem_wb_en && id_reads(mem_dest, id_valid, id_src1, id_src2, id_two_src));
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
    end
`endif

    // Memory-wait FSM next state, then pipeline control with freeze > branch > hazard priority.
    always_comb begin
        state_next   = state;
        wait_next    = wait_cnt;
        freeze       = 1'b0;
        hazard_stall = 1'b0;
        if_en        = 1'b0;
        id_en        = 1'b0;
        exe_en       = 1'b0;
        mem_en       = 1'b0;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        fwd_a_sel    = 2'b00;
        fwd_b_sel    = 2'b00;

        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze     = 1'b1;
                    state_next = MWAIT;
                    wait_next  = WAIT_W'(1);
                end
            end
            MWAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_next = ERR;
                    end else begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase

        if (rst) begin
            fwd_a_sel = fwd_a_raw;
            fwd_b_sel = fwd_b_raw;
            if (freeze) begin
                if_en  = 1'b0;
                id_en  = 1'b0;
                exe_en = 1'b0;
                mem_en = 1'b0;
            end else if (branch_taken) begin
                if_en    = 1'b1;
                id_en    = 1'b1;
                exe_en   = 1'b1;
                mem_en   = 1'b1;
                if_flush = 1'b1;
                id_flush = 1'b1;
            end else if (hazard) begin
                hazard_stall = 1'b1;
                exe_en       = 1'b1;
                mem_en       = 1'b1;
                id_flush     = 1'b1;
            end else begin
                if_en  = 1'b1;
                id_en  = 1'b1;
                exe_en = 1'b1;
                mem_en = 1'b1;
            end
        end
    end

    assign stall_inc = rst && (freeze || hazard_stall);
    assign mem_err   = (state == ERR);

    // FSM state and memory-wait counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Saturating count of cycles lost to freezes and hazard bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl with a queue scoreboard.
// The driver pushes hand-labelled expectations; a negedge monitor pops and compares.
// Expectations for forwarding depend on whether FORWARDING_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;

`ifdef FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [4:0] id_src1;
        logic [4:0] id_src2;
        logic       id_two_src;
        logic [4:0] exe_src1;
        logic [4:0] exe_src2;
        logic [4:0] exe_dest;
        logic       exe_wb_en;
        logic       exe_mem_r_en;
        logic [4:0] mem_dest;
        logic       mem_wb_en;
        logic [4:0] wb_dest;
        logic       wb_en;
        logic       branch_taken;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    typedef struct packed {
        logic [3:0]       en;
        logic [1:0]       fl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             err;
        logic             chk_err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef enum int {C_RESET, C_NORMAL, C_BRANCH, C_STALL, C_FREEZE} cls_e;

    logic             clk;
    stim_t            s;
    logic             if_en, id_en, exe_en, mem_en;
    logic             if_flush, id_flush;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    exp_t             exp_q[$];
    string            name_q[$];
    logic [CNT_W-1:0] exp_cnt;
    int               pass_cnt;
    int               total_cnt;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (s.rst),
        .id_valid    (s.id_valid),
        .id_src1     (s.id_src1),
        .id_src2     (s.id_src2),
        .id_two_src  (s.id_two_src),
        .exe_src1    (s.exe_src1),
        .exe_src2    (s.exe_src2),
        .exe_dest    (s.exe_dest),
        .exe_wb_en   (s.exe_wb_en),
        .exe_mem_r_en(s.exe_mem_r_en),
        .mem_dest    (s.mem_dest),
        .mem_wb_en   (s.mem_wb_en),
        .wb_dest     (s.wb_dest),
        .wb_en       (s.wb_en),
        .branch_taken(s.branch_taken),
        .mem_req     (s.mem_req),
        .mem_ready   (s.mem_ready),
        .if_en       (if_en),
        .id_en       (id_en),
        .exe_en      (exe_en),
        .mem_en      (mem_en),
        .if_flush    (if_flush),
        .id_flush    (id_flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Idle pipeline with reset released.
    function automatic stim_t blank();
        stim_t v;
        v     = '0;
        v.rst = 1'b1;
        return v;
    endfunction

    // Load r5 in EXE while ID holds add r6,r5,r1.
    function automatic stim_t loadUse();
        stim_t v;
        v              = blank();
        v.id_valid     = 1'b1;
        v.id_src1      = 5'd5;
        v.id_src2      = 5'd1;
        v.id_two_src   = 1'b1;
        v.exe_dest     = 5'd5;
        v.exe_wb_en    = 1'b1;
        v.exe_mem_r_en = 1'b1;
        return v;
    endfunction

    // Drive one vector just after the clock edge and queue its expected response.
    task automatic applyStimulus(input stim_t v, input cls_e cls, input logic [1:0] fa,
                                 input logic [1:0] fb, input logic err, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        s         = v;
        e         = '0;
        e.fa      = fa;
        e.fb      = fb;
        e.err     = err;
        e.chk_err = (cls != C_RESET);
        e.cnt     = exp_cnt;
        case (cls)
            C_NORMAL: begin e.en = 4'b1111; e.fl = 2'b00; end
            C_BRANCH: begin e.en = 4'b1111; e.fl = 2'b11; end
            C_STALL:  begin e.en = 4'b0011; e.fl = 2'b01; end
            default:  begin e.en = 4'b0000; e.fl = 2'b00; end
        endcase
        exp_q.push_back(e);
        name_q.push_back(name);
        if (cls == C_RESET) begin
            exp_cnt = '0;
        end else if ((cls == C_STALL || cls == C_FREEZE) && exp_cnt != '1) begin
            exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    // Single field comparison.
    task automatic checkField(input string vec, input string field,
                              input logic [15:0] got, input logic [15:0] want);
        total_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s.%s got %0h expected %0h", vec, field, got, want);
        end
    endtask

    // Compare the DUT outputs against the oldest queued expectation.
    task automatic checkOutput();
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkField(n, "enables", 16'({if_en, id_en, exe_en, mem_en}), 16'(e.en));
        checkField(n, "flushes", 16'({if_flush, id_flush}), 16'(e.fl));
        checkField(n, "fwd_a_sel", 16'(fwd_a_sel), 16'(e.fa));
        checkField(n, "fwd_b_sel", 16'(fwd_b_sel), 16'(e.fb));
        checkField(n, "stall_cnt", 16'(stall_cnt), 16'(e.cnt));
        if (e.chk_err) begin
            checkField(n, "mem_err", 16'(mem_err), 16'(e.err));
        end
    endtask

    // Monitor: sample on the falling edge whenever a vector is outstanding.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            checkOutput();
        end
    end

    // Directed stimulus sequence.
    initial begin
        stim_t v;
        pass_cnt  = 0;
        total_cnt = 0;
        exp_cnt   = '0;
        s         = '0;
        repeat (2) @(posedge clk);

        v = loadUse(); v.rst = 1'b0; v.branch_taken = 1'b1;
        v.exe_src1 = 5'd3; v.mem_dest = 5'd3; v.mem_wb_en = 1'b1;
        applyStimulus(v, C_RESET, 2'b00, 2'b00, 1'b0, "reset_outputs_zero");
        applyStimulus(blank(), C_NORMAL, 2'b00, 2'b00, 1'b0, "idle");

        applyStimulus(loadUse(), C_STALL, 2'b00, 2'b00, 1'b0, "load_use");
        v = blank(); v.id_valid = 1'b1; v.id_src1 = 5'd5; v.id_src2 = 5'd1; v.id_two_src = 1'b1;
        applyStimulus(v, C_NORMAL, 2'b00, 2'b00, 1'b0, "after_load_use");

        v = loadUse(); v.id_src1 = 5'd0; v.exe_dest = 5'd0;
        applyStimulus(v, C_NORMAL, 2'b00, 2'b00, 1'b0, "reg0_no_match");
        v = loadUse(); v.id_src1 = 5'd2; v.id_src2 = 5'd7; v.id_two_src = 1'b0; v.exe_dest = 5'd7;
        applyStimulus(v, C_NORMAL, 2'b00, 2'b00, 1'b0, "src2_ignored");
        v.id_two_src = 1'b1;
        applyStimulus(v, C_STALL, 2'b00, 2'b00, 1'b0, "src2_match");
        v.id_valid = 1'b0;
        applyStimulus(v, C_NORMAL, 2'b00, 2'b00, 1'b0, "id_invalid");

        v = loadUse(); v.branch_taken = 1'b1;
        applyStimulus(v, C_BRANCH, 2'b00, 2'b00, 1'b0, "hazard_and_branch");

        v = blank(); v.id_valid = 1'b1; v.id_src1 = 5'd9; v.exe_dest = 5'd9; v.exe_wb_en = 1'b1;
        applyStimulus(v, FWD_ON ? C_NORMAL : C_STALL, 2'b00, 2'b00, 1'b0, "raw_exe_alu");
        v = blank(); v.id_valid = 1'b1; v.id_src1 = 5'd9; v.mem_dest = 5'd9; v.mem_wb_en = 1'b1;
        applyStimulus(v, FWD_ON ? C_NORMAL : C_STALL, 2'b00, 2'b00, 1'b0, "raw_mem");

        v = blank(); v.exe_src1 = 5'd3; v.exe_src2 = 5'd4;
        v.mem_dest = 5'd3; v.mem_wb_en = 1'b1; v.wb_dest = 5'd3; v.wb_en = 1'b1;
        applyStimulus(v, C_NORMAL, FWD_ON ? 2'b01 : 2'b00, 2'b00, 1'b0, "fwd_mem_over_wb");
        v.mem_wb_en = 1'b0;
        applyStimulus(v, C_NORMAL, FWD_ON ? 2'b10 : 2'b00, 2'b00, 1'b0, "fwd_wb_only");
        v.wb_dest = 5'd4;
        applyStimulus(v, C_NORMAL, 2'b00, FWD_ON ? 2'b10 : 2'b00, 1'b0, "fwd_b_wb");
        v = blank(); v.mem_dest = 5'd0; v.mem_wb_en = 1'b1; v.wb_dest = 5'd0; v.wb_en = 1'b1;
        applyStimulus(v, C_NORMAL, 2'b00, 2'b00, 1'b0, "fwd_reg0");

        v = loadUse(); v.branch_taken = 1'b1; v.mem_req = 1'b1;
        v.exe_src1 = 5'd3; v.mem_dest = 5'd3; v.mem_wb_en = 1'b1;
        applyStimulus(v, C_FREEZE, FWD_ON ? 2'b01 : 2'b00, 2'b00, 1'b0, "mwait_1");
        applyStimulus(v, C_FREEZE, FWD_ON ? 2'b01 : 2'b00, 2'b00, 1'b0, "mwait_2");
        applyStimulus(v, C_FREEZE, FWD_ON ? 2'b01 : 2'b00, 2'b00, 1'b0, "mwait_3");
        v = blank(); v.mem_req = 1'b1; v.mem_ready = 1'b1;
        applyStimulus(v, C_NORMAL, 2'b00, 2'b00, 1'b0, "mwait_ready");
        applyStimulus(v, C_NORMAL, 2'b00, 2'b00, 1'b0, "run_req_ready");

        for (int i = 0; i < MEM_TIMEOUT + 6; i++) begin
            v = blank();
            if (i < MEM_TIMEOUT) begin
                v.mem_req = 1'b1;
                applyStimulus(v, C_FREEZE, 2'b00, 2'b00, 1'b0, $sformatf("timeout_wait_%0d", i));
            end else begin
                v.mem_ready = 1'b1; v.branch_taken = 1'b1;
                applyStimulus(v, C_FREEZE, 2'b00, 2'b00, 1'b1, $sformatf("err_frozen_%0d", i));
            end
        end

        v = loadUse(); v.rst = 1'b0; v.branch_taken = 1'b1;
        applyStimulus(v, C_RESET, 2'b00, 2'b00, 1'b0, "reset_from_err");
        applyStimulus(blank(), C_NORMAL, 2'b00, 2'b00, 1'b0, "after_err_reset");

        v = blank(); v.mem_req = 1'b1;
        applyStimulus(v, C_FREEZE, 2'b00, 2'b00, 1'b0, "mid_wait_1");
        applyStimulus(v, C_FREEZE, 2'b00, 2'b00, 1'b0, "mid_wait_2");
        v.rst = 1'b0;
        applyStimulus(v, C_RESET, 2'b00, 2'b00, 1'b0, "reset_mid_wait");
        applyStimulus(blank(), C_NORMAL, 2'b00, 2'b00, 1'b0, "back_in_run");
        applyStimulus(loadUse(), C_STALL, 2'b00, 2'b00, 1'b0, "stall_after_reset");
        applyStimulus(blank(), C_NORMAL, 2'b00, 2'b00, 1'b0, "count_resumed");

        repeat (2) @(posedge clk);
        total_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
